axi_lite_to_axi: RTL and testbench

// - AXI4-Lite slave to AXI4 master bridge: lets Lite initiators (config masters, debug) reach AXI4 fabric.
// - Each Lite transaction becomes one single-beat AXI4 burst with a fixed ID and fixed attributes.
// - All five channels are registered (one-entry spill slices).
// - Outstanding reads and writes are counted and bounded by parameters.
// - Sits between a Lite crossbar port and an AXI4 crossbar slave port.
//

---
 rtl/axi_lite_to_axi.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_to_axi.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_axi.sv
// axi_lite_to_axi: AXI4-Lite slave to AXI4 master bridge.
// Each Lite transaction becomes one single-beat INCR burst with a fixed ID
// and fixed attributes. All five channels pass through one-entry registered
// slices. Outstanding reads and writes are counted and bounded.
// Optional feature macro: AXI_LITE_TO_AXI_ID_CHECK_EN. When it is defined, a
// B or R beat whose ID differs from AXI_ID is forwarded with resp = SLVERR.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid & ready are both 1. A valid, once raised, holds its payload stable
// until that transfer. No valid output depends combinationally on a ready
// input.
module axi_lite_to_axi #(
    parameter int unsigned     ADDR_W         = 32,
    parameter int unsigned     DATA_W         = 32,
    parameter int unsigned     ID_W           = 4,
    parameter int unsigned     USER_W         = 1,
    parameter int unsigned     NUM_PENDING_RD = 4,
    parameter int unsigned     NUM_PENDING_WR = 4,
    parameter logic [ID_W-1:0] AXI_ID         = '0,
    parameter logic [3:0]      AXI_CACHE      = 4'b0000,
    localparam int unsigned    RD_CW          = $clog2(NUM_PENDING_RD + 1),
    localparam int unsigned    WR_CW          = $clog2(NUM_PENDING_WR + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // Lite slave port
    input  logic [ADDR_W-1:0]   in_aw_addr_i,
    input  logic [2:0]          in_aw_prot_i,
    input  logic                in_aw_valid_i,
    output logic                in_aw_ready_o,
    input  logic [DATA_W-1:0]   in_w_data_i,
    input  logic [DATA_W/8-1:0] in_w_strb_i,
    input  logic                in_w_valid_i,
    output logic                in_w_ready_o,
    output logic [1:0]          in_b_resp_o,
    output logic                in_b_valid_o,
    input  logic                in_b_ready_i,
    input  logic [ADDR_W-1:0]   in_ar_addr_i,
    input  logic [2:0]          in_ar_prot_i,
    input  logic                in_ar_valid_i,
    output logic                in_ar_ready_o,
    output logic [DATA_W-1:0]   in_r_data_o,
    output logic [1:0]          in_r_resp_o,
    output logic                in_r_valid_o,
    input  logic                in_r_ready_i,
    // AXI4 master port
    output logic [ID_W-1:0]     out_aw_id_o,
    output logic [ADDR_W-1:0]   out_aw_addr_o,
    output logic [7:0]          out_aw_len_o,
    output logic [2:0]          out_aw_size_o,
    output logic [1:0]          out_aw_burst_o,
    output logic                out_aw_lock_o,
    output logic [3:0]          out_aw_cache_o,
    output logic [2:0]          out_aw_prot_o,
    output logic [3:0]          out_aw_qos_o,
    output logic [3:0]          out_aw_region_o,
    output logic [5:0]          out_aw_atop_o,
    output logic [USER_W-1:0]   out_aw_user_o,
    output logic                out_aw_valid_o,
    input  logic                out_aw_ready_i,
    output logic [DATA_W-1:0]   out_w_data_o,
    output logic [DATA_W/8-1:0] out_w_strb_o,
    output logic                out_w_last_o,
    output logic [USER_W-1:0]   out_w_user_o,
    output logic                out_w_valid_o,
    input  logic                out_w_ready_i,
    input  logic [ID_W-1:0]     out_b_id_i,
    input  logic [1:0]          out_b_resp_i,
    input  logic [USER_W-1:0]   out_b_user_i,
    input  logic                out_b_valid_i,
    output logic                out_b_ready_o,
    output logic [ID_W-1:0]     out_ar_id_o,
    output logic [ADDR_W-1:0]   out_ar_addr_o,
    output logic [7:0]          out_ar_len_o,
    output logic [2:0]          out_ar_size_o,
    output logic [1:0]          out_ar_burst_o,
    output logic                out_ar_lock_o,
    output logic [3:0]          out_ar_cache_o,
    output logic [2:0]          out_ar_prot_o,
    output logic [3:0]          out_ar_qos_o,
    output logic [3:0]          out_ar_region_o,
    output logic [USER_W-1:0]   out_ar_user_o,
    output logic                out_ar_valid_o,
    input  logic                out_ar_ready_i,
    input  logic [ID_W-1:0]     out_r_id_i,
    input  logic [DATA_W-1:0]   out_r_data_i,
    input  logic [1:0]          out_r_resp_i,
    input  logic                out_r_last_i,
    input  logic [USER_W-1:0]   out_r_user_i,
    input  logic                out_r_valid_i,
    output logic                out_r_ready_o,
    // Debug view of the pending counters
    output logic [WR_CW-1:0]    wr_cnt_o,
    output logic [RD_CW-1:0]    rd_cnt_o
);

    localparam logic [2:0]   AX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [1:0]   BURST_INCR = 2'b01;
    localparam logic [1:0]   RESP_SLVERR = 2'b10;
    localparam logic [WR_CW:0] WR_LIM = (WR_CW + 1)'(NUM_PENDING_WR);
    localparam logic [RD_CW:0] RD_LIM = (RD_CW + 1)'(NUM_PENDING_RD);

    // Slice registers
    logic                aw_valid_q, aw_valid_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [2:0]          aw_prot_q, aw_prot_d;
    logic                w_valid_q, w_valid_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
    logic                ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic [2:0]          ar_prot_q, ar_prot_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q, b_resp_d;
    logic                r_valid_q, r_valid_d;
    logic [DATA_W-1:0]   r_data_q, r_data_d;
    logic [1:0]          r_resp_q, r_resp_d;
    logic [WR_CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [RD_CW-1:0]    rd_cnt_q, rd_cnt_d;

    logic aw_out_hs, ar_out_hs, b_out_hs, r_out_hs;
    logic wr_dec, rd_dec;
    logic [1:0] b_resp_chk, r_resp_chk;
    logic [WR_CW:0] wr_committed;
    logic [RD_CW:0] rd_committed;

    assign aw_out_hs = aw_valid_q & out_aw_ready_i;
    assign ar_out_hs = ar_valid_q & out_ar_ready_i;
    assign b_out_hs  = out_b_valid_i & out_b_ready_o;
    assign r_out_hs  = out_r_valid_i & out_r_ready_o;

    // A response only retires a transaction when one is outstanding;
    // unsolicited responses are accepted and dropped.
    assign wr_dec = b_out_hs & (wr_cnt_q != '0);
    assign rd_dec = r_out_hs & out_r_last_i & (rd_cnt_q != '0);

    // The slice occupant is counted too, so the counter can never be pushed
    // past its limit by an entry already accepted but not yet sent.
    assign wr_committed = {1'b0, wr_cnt_q} + {{WR_CW{1'b0}}, aw_valid_q};
    assign rd_committed = {1'b0, rd_cnt_q} + {{RD_CW{1'b0}}, ar_valid_q};

    assign in_aw_ready_o = (~aw_valid_q | out_aw_ready_i) & (wr_committed < WR_LIM);
    assign in_ar_ready_o = (~ar_valid_q | out_ar_ready_i) & (rd_committed < RD_LIM);
    assign in_w_ready_o  = ~w_valid_q | out_w_ready_i;
    assign out_b_ready_o = ~b_valid_q | in_b_ready_i;
    assign out_r_ready_o = ~r_valid_q | in_r_ready_i;

`ifdef AXI_LITE_TO_AXI_ID_CHECK_EN
    assign b_resp_chk = (out_b_id_i != AXI_ID) ? RESP_SLVERR : out_b_resp_i;
    assign r_resp_chk = (out_r_id_i != AXI_ID) ? RESP_SLVERR : out_r_resp_i;
    logic unused_sig;
    assign unused_sig = ^{out_b_user_i, out_r_user_i};
`else
    assign b_resp_chk = out_b_resp_i;
    assign r_resp_chk = out_r_resp_i;
    logic unused_sig;
    assign unused_sig = ^{out_b_user_i, out_r_user_i, out_b_id_i, out_r_id_i, RESP_SLVERR};
`endif

    // Request slices (AW, W, AR): empty on downstream accept, refill on upstream accept
    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_prot_d  = aw_prot_q;
        if (out_aw_ready_i) aw_valid_d = 1'b0;
        if (in_aw_valid_i & in_aw_ready_o) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = in_aw_addr_i;
            aw_prot_d  = in_aw_prot_i;
        end
        w_valid_d = w_valid_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (out_w_ready_i) w_valid_d = 1'b0;
        if (in_w_valid_i & in_w_ready_o) begin
            w_valid_d = 1'b1;
            w_data_d  = in_w_data_i;
            w_strb_d  = in_w_strb_i;
        end
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_prot_d  = ar_prot_q;
        if (out_ar_ready_i) ar_valid_d = 1'b0;
        if (in_ar_valid_i & in_ar_ready_o) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = in_ar_addr_i;
            ar_prot_d  = in_ar_prot_i;
        end
    end

    // Response slices (B, R): only responses that retire a transaction are forwarded
    always_comb begin
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        if (in_b_ready_i) b_valid_d = 1'b0;
        if (wr_dec) begin
            b_valid_d = 1'b1;
            b_resp_d  = b_resp_chk;
        end
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (in_r_ready_i) r_valid_d = 1'b0;
        if (rd_dec) begin
            r_valid_d = 1'b1;
            r_data_d  = out_r_data_i;
            r_resp_d  = r_resp_chk;
        end
    end

    // Pending counters: a simultaneous increment and decrement cancel out
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (aw_out_hs & ~wr_dec)      wr_cnt_d = wr_cnt_q + WR_CW'(1);
        else if (~aw_out_hs & wr_dec) wr_cnt_d = wr_cnt_q - WR_CW'(1);
        rd_cnt_d = rd_cnt_q;
        if (ar_out_hs & ~rd_dec)      rd_cnt_d = rd_cnt_q + RD_CW'(1);
        else if (~ar_out_hs & rd_dec) rd_cnt_d = rd_cnt_q - RD_CW'(1);
    end

    // State registers; reset flushes every slice and counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_valid_q <= 1'b0; aw_addr_q <= '0; aw_prot_q <= '0;
            w_valid_q  <= 1'b0; w_data_q  <= '0; w_strb_q  <= '0;
            ar_valid_q <= 1'b0; ar_addr_q <= '0; ar_prot_q <= '0;
            b_valid_q  <= 1'b0; b_resp_q  <= '0;
            r_valid_q  <= 1'b0; r_data_q  <= '0; r_resp_q  <= '0;
            wr_cnt_q   <= '0;   rd_cnt_q  <= '0;
        end else begin
            aw_valid_q <= aw_valid_d; aw_addr_q <= aw_addr_d; aw_prot_q <= aw_prot_d;
            w_valid_q  <= w_valid_d;  w_data_q  <= w_data_d;  w_strb_q  <= w_strb_d;
            ar_valid_q <= ar_valid_d; ar_addr_q <= ar_addr_d; ar_prot_q <= ar_prot_d;
            b_valid_q  <= b_valid_d;  b_resp_q  <= b_resp_d;
            r_valid_q  <= r_valid_d;  r_data_q  <= r_data_d;  r_resp_q  <= r_resp_d;
            wr_cnt_q   <= wr_cnt_d;   rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign out_aw_valid_o  = aw_valid_q;
    assign out_aw_id_o     = AXI_ID;
    assign out_aw_addr_o   = aw_addr_q;
    assign out_aw_len_o    = 8'd0;
    assign out_aw_size_o   = AX_SIZE;
    assign out_aw_burst_o  = BURST_INCR;
    assign out_aw_lock_o   = 1'b0;
    assign out_aw_cache_o  = AXI_CACHE;
    assign out_aw_prot_o   = aw_prot_q;
    assign out_aw_qos_o    = 4'd0;
    assign out_aw_region_o = 4'd0;
    assign out_aw_atop_o   = 6'd0;
    assign out_aw_user_o   = '0;

    assign out_w_valid_o   = w_valid_q;
    assign out_w_data_o    = w_data_q;
    assign out_w_strb_o    = w_strb_q;
    assign out_w_last_o    = 1'b1;
    assign out_w_user_o    = '0;

    assign out_ar_valid_o  = ar_valid_q;
    assign out_ar_id_o     = AXI_ID;
    assign out_ar_addr_o   = ar_addr_q;
    assign out_ar_len_o    = 8'd0;
    assign out_ar_size_o   = AX_SIZE;
    assign out_ar_burst_o  = BURST_INCR;
    assign out_ar_lock_o   = 1'b0;
    assign out_ar_cache_o  = AXI_CACHE;
    assign out_ar_prot_o   = ar_prot_q;
    assign out_ar_qos_o    = 4'd0;
    assign out_ar_region_o = 4'd0;
    assign out_ar_user_o   = '0;

    assign in_b_valid_o    = b_valid_q;
    assign in_b_resp_o     = b_resp_q;
    assign in_r_valid_o    = r_valid_q;
    assign in_r_data_o     = r_data_q;
    assign in_r_resp_o     = r_resp_q;

    assign wr_cnt_o        = wr_cnt_q;
    assign rd_cnt_o        = rd_cnt_q;

endmodule

// File: tb/tb_axi_lite_to_axi.sv
// Directed bench for axi_lite_to_axi: Lite writes/reads, pending limits,
// counter cancellation, backpressure, dropped beats and the optional ID check.
module tb_axi_lite_to_axi;

    localparam int unsigned     ADDR_W = 32;
    localparam int unsigned     DATA_W = 32;
    localparam int unsigned     ID_W   = 4;
    localparam int unsigned     USER_W = 1;
    localparam logic [ID_W-1:0] TB_ID  = 4'h3;
    localparam logic [3:0]      TB_CACHE = 4'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [ADDR_W-1:0] in_aw_addr = '0;  logic [2:0] in_aw_prot = '0;
    logic in_aw_valid = 1'b0;            logic in_aw_ready;
    logic [DATA_W-1:0] in_w_data = '0;   logic [3:0] in_w_strb = '0;
    logic in_w_valid = 1'b0;             logic in_w_ready;
    logic [1:0] in_b_resp;  logic in_b_valid;  logic in_b_ready = 1'b1;
    logic [ADDR_W-1:0] in_ar_addr = '0;  logic [2:0] in_ar_prot = '0;
    logic in_ar_valid = 1'b0;            logic in_ar_ready;
    logic [DATA_W-1:0] in_r_data;  logic [1:0] in_r_resp;
    logic in_r_valid;  logic in_r_ready = 1'b1;

    logic [ID_W-1:0] aw_id;  logic [ADDR_W-1:0] aw_addr;  logic [7:0] aw_len;
    logic [2:0] aw_size;  logic [1:0] aw_burst;  logic aw_lock;  logic [3:0] aw_cache;
    logic [2:0] aw_prot;  logic [3:0] aw_qos;  logic [3:0] aw_region;  logic [5:0] aw_atop;
    logic [USER_W-1:0] aw_user;  logic aw_valid;  logic aw_ready = 1'b1;
    logic [DATA_W-1:0] w_data;  logic [3:0] w_strb;  logic w_last;  logic [USER_W-1:0] w_user;
    logic w_valid;  logic w_ready = 1'b1;
    logic [ID_W-1:0] b_id = TB_ID;  logic [1:0] b_resp = '0;  logic [USER_W-1:0] b_user = '0;
    logic b_valid = 1'b0;  logic b_ready;
    logic [ID_W-1:0] ar_id;  logic [ADDR_W-1:0] ar_addr;  logic [7:0] ar_len;
    logic [2:0] ar_size;  logic [1:0] ar_burst;  logic ar_lock;  logic [3:0] ar_cache;
    logic [2:0] ar_prot;  logic [3:0] ar_qos;  logic [3:0] ar_region;
    logic [USER_W-1:0] ar_user;  logic ar_valid;  logic ar_ready = 1'b1;
    logic [ID_W-1:0] r_id = TB_ID;  logic [DATA_W-1:0] r_data = '0;  logic [1:0] r_resp = '0;
    logic r_last = 1'b0;  logic [USER_W-1:0] r_user = '0;  logic r_valid = 1'b0;  logic r_ready;
    logic [2:0] wr_cnt;  logic [2:0] rd_cnt;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    axi_lite_to_axi #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W),
        .NUM_PENDING_RD(4), .NUM_PENDING_WR(4), .AXI_ID(TB_ID), .AXI_CACHE(TB_CACHE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_aw_addr_i(in_aw_addr), .in_aw_prot_i(in_aw_prot), .in_aw_valid_i(in_aw_valid),
        .in_aw_ready_o(in_aw_ready),
        .in_w_data_i(in_w_data), .in_w_strb_i(in_w_strb), .in_w_valid_i(in_w_valid),
        .in_w_ready_o(in_w_ready),
        .in_b_resp_o(in_b_resp), .in_b_valid_o(in_b_valid), .in_b_ready_i(in_b_ready),
        .in_ar_addr_i(in_ar_addr), .in_ar_prot_i(in_ar_prot), .in_ar_valid_i(in_ar_valid),
        .in_ar_ready_o(in_ar_ready),
        .in_r_data_o(in_r_data), .in_r_resp_o(in_r_resp), .in_r_valid_o(in_r_valid),
        .in_r_ready_i(in_r_ready),
        .out_aw_id_o(aw_id), .out_aw_addr_o(aw_addr), .out_aw_len_o(aw_len),
        .out_aw_size_o(aw_size), .out_aw_burst_o(aw_burst), .out_aw_lock_o(aw_lock),
        .out_aw_cache_o(aw_cache), .out_aw_prot_o(aw_prot), .out_aw_qos_o(aw_qos),
        .out_aw_region_o(aw_region), .out_aw_atop_o(aw_atop), .out_aw_user_o(aw_user),
        .out_aw_valid_o(aw_valid), .out_aw_ready_i(aw_ready),
        .out_w_data_o(w_data), .out_w_strb_o(w_strb), .out_w_last_o(w_last),
        .out_w_user_o(w_user), .out_w_valid_o(w_valid), .out_w_ready_i(w_ready),
        .out_b_id_i(b_id), .out_b_resp_i(b_resp), .out_b_user_i(b_user),
        .out_b_valid_i(b_valid), .out_b_ready_o(b_ready),
        .out_ar_id_o(ar_id), .out_ar_addr_o(ar_addr), .out_ar_len_o(ar_len),
        .out_ar_size_o(ar_size), .out_ar_burst_o(ar_burst), .out_ar_lock_o(ar_lock),
        .out_ar_cache_o(ar_cache), .out_ar_prot_o(ar_prot), .out_ar_qos_o(ar_qos),
        .out_ar_region_o(ar_region), .out_ar_user_o(ar_user),
        .out_ar_valid_o(ar_valid), .out_ar_ready_i(ar_ready),
        .out_r_id_i(r_id), .out_r_data_i(r_data), .out_r_resp_i(r_resp),
        .out_r_last_i(r_last), .out_r_user_i(r_user),
        .out_r_valid_i(r_valid), .out_r_ready_o(r_ready),
        .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected read data and compare it with the Lite R output
    task automatic check_r(input string tag);
        logic [DATA_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(in_r_data), 64'(e));
        end
    endtask

    // One Lite AW handshake (slice has room at the call sites)
    task automatic send_aw(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        in_aw_valid = 1'b1; in_aw_addr = a;
        @(negedge clk);
        in_aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        in_ar_valid = 1'b1; in_ar_addr = a;
        @(negedge clk);
        in_ar_valid = 1'b0;
    endtask

    // One downstream R beat presented for exactly one rising edge
    task automatic r_beat(input logic [DATA_W-1:0] d, input logic [1:0] rs,
                          input logic lst, input logic [ID_W-1:0] id);
        @(negedge clk);
        r_valid = 1'b1; r_data = d; r_resp = rs; r_last = lst; r_id = id;
        @(negedge clk);
        r_valid = 1'b0;
    endtask

    task automatic b_beat(input logic [1:0] rs, input logic [ID_W-1:0] id);
        @(negedge clk);
        b_valid = 1'b1; b_resp = rs; b_id = id;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    initial begin
        int n_in;
        int n_out;
        logic [ID_W-1:0] bad_id;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_b_valid", 64'(in_b_valid), 64'd0);
        check("rst_r_valid", 64'(in_r_valid), 64'd0);
        check("rst_aw_ready", 64'(in_aw_ready), 64'd1);
        check("rst_w_ready", 64'(in_w_ready), 64'd1);
        check("rst_ar_ready", 64'(in_ar_ready), 64'd1);
        check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);

        // Lite write 0x40 / 0xDEADBEEF, downstream stalled for one cycle
        aw_ready = 1'b0; w_ready = 1'b0;
        @(negedge clk);
        in_aw_valid = 1'b1; in_aw_addr = 32'h40; in_aw_prot = 3'b010;
        in_w_valid = 1'b1; in_w_data = 32'hDEADBEEF; in_w_strb = 4'hF;
        @(negedge clk);
        in_aw_valid = 1'b0; in_w_valid = 1'b0;
        #1;
        check("wr_aw_valid", 64'(aw_valid), 64'd1);
        check("wr_aw_addr", 64'(aw_addr), 64'h40);
        check("wr_aw_len", 64'(aw_len), 64'd0);
        check("wr_aw_size", 64'(aw_size), 64'd2);
        check("wr_aw_burst", 64'(aw_burst), 64'd1);
        check("wr_aw_id", 64'(aw_id), 64'(TB_ID));
        check("wr_aw_cache", 64'(aw_cache), 64'(TB_CACHE));
        check("wr_aw_prot", 64'(aw_prot), 64'd2);
        check("wr_aw_misc", 64'({aw_lock, aw_qos, aw_region, aw_atop, aw_user}), 64'd0);
        check("wr_aw_ready_full", 64'(in_aw_ready), 64'd0);
        check("wr_w_valid", 64'(w_valid), 64'd1);
        check("wr_w_data", 64'(w_data), 64'hDEADBEEF);
        check("wr_w_strb", 64'(w_strb), 64'hF);
        check("wr_w_last", 64'(w_last), 64'd1);
        check("wr_cnt_before", 64'(wr_cnt), 64'd0);
        aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk); #1;
        check("wr_aw_drained", 64'(aw_valid), 64'd0);
        check("wr_w_drained", 64'(w_valid), 64'd0);
        check("wr_cnt_one", 64'(wr_cnt), 64'd1);
        b_beat(2'b00, TB_ID);
        #1;
        check("wr_b_valid", 64'(in_b_valid), 64'd1);
        check("wr_b_resp", 64'(in_b_resp), 64'd0);
        check("wr_cnt_zero", 64'(wr_cnt), 64'd0);
        @(negedge clk); #1;
        check("wr_b_done", 64'(in_b_valid), 64'd0);

        // Lite read 0x80, rd_cnt 0 -> 1 -> 0
        send_ar(32'h80);
        #1;
        check("rd_ar_valid", 64'(ar_valid), 64'd1);
        check("rd_ar_addr", 64'(ar_addr), 64'h80);
        check("rd_ar_id", 64'(ar_id), 64'(TB_ID));
        check("rd_cnt_0", 64'(rd_cnt), 64'd0);
        @(negedge clk); #1;
        check("rd_cnt_1", 64'(rd_cnt), 64'd1);
        exp_q.push_back(32'h12345678);
        r_beat(32'h12345678, 2'b00, 1'b1, TB_ID);
        #1;
        check("rd_r_valid", 64'(in_r_valid), 64'd1);
        check_r("rd_r_data");
        check("rd_r_resp", 64'(in_r_resp), 64'd0);
        check("rd_cnt_2", 64'(rd_cnt), 64'd0);

        // Five ARs with R stalled: only four get out
        n_in = 0; n_out = 0;
        @(negedge clk);
        in_ar_valid = 1'b1; in_ar_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (in_ar_valid && in_ar_ready) n_in++;
            if (ar_valid && ar_ready) n_out++;
            @(negedge clk);
        end
        #1;
        check("lim_in_count", 64'(n_in), 64'd4);
        check("lim_out_count", 64'(n_out), 64'd4);
        check("lim_ar_ready", 64'(in_ar_ready), 64'd0);
        check("lim_rd_cnt", 64'(rd_cnt), 64'd4);
        exp_q.push_back(32'h11);
        @(negedge clk);
        r_valid = 1'b1; r_data = 32'h11; r_resp = 2'b00; r_last = 1'b1; r_id = TB_ID;
        @(negedge clk);
        r_valid = 1'b0;
        #1;
        check("lim_ar_ready_back", 64'(in_ar_ready), 64'd1);
        check("lim_rd_cnt_3", 64'(rd_cnt), 64'd3);
        check_r("lim_r_data");
        @(negedge clk);
        in_ar_valid = 1'b0;
        @(negedge clk); #1;
        check("lim_rd_cnt_refill", 64'(rd_cnt), 64'd4);
        for (int i = 0; i < 4; i++) r_beat(32'(i), 2'b00, 1'b1, TB_ID);
        #1;
        check("lim_rd_cnt_drain", 64'(rd_cnt), 64'd0);

        // Simultaneous AW and B handshake at wr_cnt == 2
        send_aw(32'h10);
        send_aw(32'h14);
        @(negedge clk); #1;
        check("sim_wr_cnt_2", 64'(wr_cnt), 64'd2);
        aw_ready = 1'b0;
        send_aw(32'h18);
        in_b_ready = 1'b0;
        aw_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b01; b_id = TB_ID;
        #1;
        check("sim_b_ready", 64'(b_ready), 64'd1);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        check("sim_wr_cnt_stays", 64'(wr_cnt), 64'd2);
        check("sim_b_valid", 64'(in_b_valid), 64'd1);

        // in.b_ready low for 10 cycles with another B waiting downstream
        b_valid = 1'b1; b_resp = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("bp_b_valid", 64'(in_b_valid), 64'd1);
            check("bp_b_resp", 64'(in_b_resp), 64'd1);
            check("bp_out_b_ready", 64'(b_ready), 64'd0);
        end
        in_b_ready = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        check("bp_b_next_resp", 64'(in_b_resp), 64'd2);
        check("bp_wr_cnt_1", 64'(wr_cnt), 64'd1);
        b_beat(2'b00, TB_ID);
        #1;
        check("bp_wr_cnt_0", 64'(wr_cnt), 64'd0);

        // Unsolicited B at wr_cnt == 0 is dropped
        b_beat(2'b11, TB_ID);
        #1;
        check("unsol_b_valid", 64'(in_b_valid), 64'd0);
        check("unsol_wr_cnt", 64'(wr_cnt), 64'd0);

        // Non-last R beat discarded, last beat forwarded
        send_ar(32'h100);
        @(negedge clk); #1;
        check("nl_rd_cnt_1", 64'(rd_cnt), 64'd1);
        r_beat(32'hAAAA, 2'b00, 1'b0, TB_ID);
        #1;
        check("nl_r_valid", 64'(in_r_valid), 64'd0);
        check("nl_rd_cnt_kept", 64'(rd_cnt), 64'd1);
        exp_q.push_back(32'h5555);
        r_beat(32'h5555, 2'b00, 1'b1, TB_ID);
        #1;
        check("nl_last_valid", 64'(in_r_valid), 64'd1);
        check_r("nl_last_data");
        check("nl_rd_cnt_0", 64'(rd_cnt), 64'd0);

        // Unsolicited R at rd_cnt == 0 is dropped
        r_beat(32'h77, 2'b00, 1'b1, TB_ID);
        #1;
        check("unsol_r_valid", 64'(in_r_valid), 64'd0);
        check("unsol_rd_cnt", 64'(rd_cnt), 64'd0);

        // R beat with an ID other than AXI_ID
        bad_id = TB_ID + 4'd1;
        send_ar(32'h180);
        @(negedge clk);
        exp_q.push_back(32'h9);
        r_beat(32'h9, 2'b00, 1'b1, bad_id);
        #1;
        check("id_r_valid", 64'(in_r_valid), 64'd1);
        check_r("id_r_data");
`ifdef AXI_LITE_TO_AXI_ID_CHECK_EN
        check("id_r_resp", 64'(in_r_resp), 64'd2);
`else
        check("id_r_resp", 64'(in_r_resp), 64'd0);
`endif
        check("id_rd_cnt", 64'(rd_cnt), 64'd0);

        // Reset mid-transaction flushes slices
        send_aw(32'h300);
        aw_ready = 1'b0;
        send_aw(32'h304);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aw_ready = 1'b1;
        #1;
        check("flush_aw_valid", 64'(aw_valid), 64'd0);
        check("flush_wr_cnt", 64'(wr_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
